// File: rtl/vdec_pkg.sv
// vdec_pkg: shared types and trellis helpers for the K=3, rate-1/2 Viterbi
// decoder. Encoder state is {s0,s1}: s0 is the previous data bit (MSB), s1
// the one before it. Code bits for data bit u are c0=u^s0^s1, c1=u^s0.
package vdec_pkg;

  typedef logic [1:0] state_t;

  localparam int NUM_STATES = 4;

  // Expected code symbol {c0,c1} when the encoder sits in state p and sees u.
  function automatic logic [1:0] exp_sym(state_t p, bit u);
    logic s0, s1;
    s0 = p[1];
    s1 = p[0];
    return {u ^ s0 ^ s1, u ^ s0};
  endfunction

  // Predecessor i of next state n={u,a}: the state {a,i} that shifts into n.
  function automatic state_t pred(state_t n, bit i);
    return {n[0], i};
  endfunction

  // Hamming distance between the received pair {r0,r1} and the symbol the
  // encoder would emit on the branch (p, u). Range 0..2.
  function automatic logic [1:0] branch_metric(state_t p, bit u, logic r0, logic r1);
    logic [1:0] sym;
    sym = exp_sym(p, u);
    return {1'b0, r0 ^ sym[1]} + {1'b0, r1 ^ sym[0]};
  endfunction

endpackage

// File: rtl/vdec_acs.sv
// vdec_acs: one add-compare-select cell. Adds each predecessor's path metric
// to its branch metric and keeps the smaller; on a tie predecessor 0 wins.
// Ports:
//   pm0, pm1  in   path metrics of predecessors p0, p1
//   bm0, bm1  in   branch metrics (0..2) on the p0 / p1 branches
//   metric    out  selected candidate, one bit wider than a path metric
//   sel       out  0 = p0 chosen, 1 = p1 chosen
module vdec_acs #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W:0]   metric,
  output logic            sel
);

  logic [PM_W:0] cand0;
  logic [PM_W:0] cand1;

  // The extra bit keeps the pre-normalization sum exact.
  assign cand0  = {1'b0, pm0} + (PM_W+1)'(bm0);
  assign cand1  = {1'b0, pm1} + (PM_W+1)'(bm1);
  // Strict less-than so that equal candidates keep p0.
  assign sel    = (cand1 < cand0);
  assign metric = sel ? cand1 : cand0;

endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision Viterbi decoder for a serial K=3, rate-1/2
// code stream. Pairs code bits, runs a 4-state ACS with normalized metrics,
// keeps survivors by register exchange and emits one data bit per pair once
// TB_DEPTH pairs have been absorbed.
// Optional feature: define VDEC_ERRCNT_EN to add err_count, the running sum
// of channel errors absorbed by the best path (saturating at 16'hFFFF).
// Ports:
//   clock      in   system clock, posedge
//   reset      in   asynchronous, active-high
//   in         in   serial code bit, sampled when in_valid=1
//   in_valid   in   qualifies in
//   out        out  decoded data bit (holds between pulses)
//   out_valid  out  one-cycle pulse qualifying out
//   err_count  out  [15:0] absorbed-error count (VDEC_ERRCNT_EN only)
module viterbi_decoder
  import vdec_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in,
  input  logic        in_valid,
  output logic        out,
  output logic        out_valid
`ifdef VDEC_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int CNT_W = $clog2(TB_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TB_DEPTH - 1);
  // Non-zero start states are biased so the known encoder start state 0 wins.
  localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

  logic [PM_W-1:0]     pm        [NUM_STATES];
  logic [TB_DEPTH-1:0] path      [NUM_STATES];
  logic                phase;
  logic                r0;
  logic [CNT_W-1:0]    pair_cnt;

  logic [PM_W:0]       raw       [NUM_STATES];
  logic [NUM_STATES-1:0] sel;
  logic [PM_W:0]       raw_min;
  logic [PM_W-1:0]     pm_next   [NUM_STATES];
  logic [TB_DEPTH-1:0] path_next [NUM_STATES];
  state_t              best;

  // One ACS per next state n={u,a}; the second code bit is used straight from
  // the input so the ACS completes on the edge that accepts it.
  for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
    localparam state_t N  = state_t'(g);
    localparam state_t P0 = pred(N, 1'b0);
    localparam state_t P1 = pred(N, 1'b1);

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = branch_metric(P0, N[1], r0, in);
    assign bm1 = branch_metric(P1, N[1], r0, in);

    vdec_acs #(.PM_W(PM_W)) u_acs (
      .pm0    (pm[P0]),
      .pm1    (pm[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .metric (raw[g]),
      .sel    (sel[g])
    );

    assign path_next[g] = {path[sel[g] ? P1 : P0][TB_DEPTH-2:0], N[1]};
  end

  // NOTE: every variable gets a value before any conditional update, so no
  // latch can be inferred here.
  always_comb begin
    raw_min = raw[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (raw[i] < raw_min) raw_min = raw[i];
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      pm_next[i] = PM_W'(raw[i] - raw_min);
    end
    // Scan downward so the lowest-index zero-metric state is the one kept.
    best = '0;
    for (int i = NUM_STATES - 1; i >= 0; i--) begin
      if (raw[i] == raw_min) best = state_t'(i);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the survivor memory is reset because its contents are shifted
      // straight to the output; stale bits would otherwise appear on out.
      pm[0] <= '0;
      for (int i = 1; i < NUM_STATES; i++) pm[i] <= PM_INIT;
      for (int i = 0; i < NUM_STATES; i++) path[i] <= '0;
      phase     <= 1'b0;
      r0        <= 1'b0;
      pair_cnt  <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        phase <= ~phase;
        if (!phase) begin
          r0 <= in;
        end else begin
          for (int i = 0; i < NUM_STATES; i++) begin
            pm[i]   <= pm_next[i];
            path[i] <= path_next[i];
          end
          out       <= path_next[best][TB_DEPTH-1];
          out_valid <= (pair_cnt >= LAST_CNT);
          if (pair_cnt != LAST_CNT) pair_cnt <= pair_cnt + 1'b1;
        end
      end
    end
  end

`ifdef VDEC_ERRCNT_EN
  logic [16:0] err_sum;

  // raw_min before normalization is the growth of the best path's metric.
  assign err_sum = {1'b0, err_count} + 17'(raw_min);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (in_valid && phase) begin
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder. The driver encodes data bits with a
// behavioural K=3 encoder, optionally flips code bits, and queues the original
// data; the monitor pops one entry per out_valid pulse and also checks that a
// pulse appears exactly on the cycle after each pair from TB_DEPTH-1 onward.
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 16;
  localparam int NPAIRS   = 20;

  logic clock = 1'b0;
  logic reset;
  logic in;
  logic in_valid;
  logic out;
  logic out_valid;
`ifdef VDEC_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int   tests = 0;
  int   fails = 0;
  bit   exp_q[$];
  int   bit_cnt;
  int   ov_pulses;
  logic ov_due;
  logic ov_exp_q;
  bit   enc_s0;
  bit   enc_s1;

  bit   known[NPAIRS] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  always #5 clock = ~clock;

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
`ifdef VDEC_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected out_valid for the current cycle: due flag captured at the edge.
  always @(posedge clock or posedge reset) begin
    if (reset) ov_exp_q <= 1'b0;
    else       ov_exp_q <= ov_due;
  end

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      check("out_valid_timing", {31'b0, out_valid}, {31'b0, ov_exp_q});
      if (out_valid) begin
        ov_pulses++;
        if (exp_q.size() == 0) begin
          check("queue_nonempty_on_valid", exp_q.size(), 1);
        end else begin
          bit e;
          e = exp_q.pop_front();
          check("decoded_bit", {31'b0, out}, {31'b0, e});
        end
      end
    end
  end

  // Reference encoder straight from the code equations.
  task automatic encode(input bit u, output bit c0, output bit c1);
    c0 = u ^ enc_s0 ^ enc_s1;
    c1 = u ^ enc_s0;
    enc_s1 = enc_s0;
    enc_s0 = u;
  endtask

  // Called at posedge+1; returns at posedge+1 after the bit and its gap.
  task automatic send_bit(input logic b, input int gap);
    in       = b;
    in_valid = 1'b1;
    ov_due   = (bit_cnt % 2 == 1) && (bit_cnt / 2 >= TB_DEPTH - 1);
    bit_cnt++;
    @(posedge clock); #1;
    in_valid = 1'b0;
    ov_due   = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_pair(input bit u, input logic [1:0] flip, input int gap);
    bit c0, c1;
    encode(u, c0, c1);
    exp_q.push_back(u);
    send_bit(c0 ^ flip[1], gap);
    send_bit(c1 ^ flip[0], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    ov_due   = 1'b0;
    reset    = 1'b1;
    exp_q.delete();
    bit_cnt   = 0;
    ov_pulses = 0;
    enc_s0    = 1'b0;
    enc_s1    = 1'b0;
    @(negedge clock);
    check("reset_out", {31'b0, out}, 0);
    check("reset_out_valid", {31'b0, out_valid}, 0);
`ifdef VDEC_ERRCNT_EN
    check("reset_err_count", {16'b0, err_count}, 0);
`endif
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Whatever has not been decoded yet must be exactly the last TB_DEPTH-1 bits.
  task automatic check_tail(input string name);
    idle(3);
    check(name, exp_q.size(), TB_DEPTH - 1);
  endtask

  task automatic run_known(input bit flip_pair2, input int gap);
    for (int i = 0; i < NPAIRS; i++) begin
      send_pair(known[i], (flip_pair2 && i == 2) ? 2'b10 : 2'b00, gap);
    end
    check_tail("known_tail");
    check("known_pulses", ov_pulses, NPAIRS - TB_DEPTH + 1);
  endtask

  task automatic run_random(input int errs_per_20);
    for (int p = 0; p < 1000; p++) begin
      bit         u;
      logic [1:0] flip;
      u    = 1'($urandom_range(1, 0));
      flip = 2'b00;
      if (errs_per_20 == 2 && (p % 20 == 3 || p % 20 == 13))
        flip = ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b01;
      send_pair(u, flip, ($urandom_range(3, 0) == 0) ? 1 : 0);
    end
    check_tail("random_tail");
    check("random_pulses", ov_pulses, 1000 - TB_DEPTH + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in       = 1'b0;
    in_valid = 1'b0;
    ov_due   = 1'b0;
    @(posedge clock); #1;
    do_reset();

    // All-zero stream: 40 code bits back-to-back, five pulses, all zeros.
    for (int i = 0; i < NPAIRS; i++) send_pair(1'b0, 2'b00, 0);
    check_tail("zero_tail");
    check("zero_pulses", ov_pulses, 5);
`ifdef VDEC_ERRCNT_EN
    check("zero_err_count", {16'b0, err_count}, 0);
`endif

    // Known stream 1,0,1,1 then zeros.
    do_reset();
    run_known(1'b0, 0);
`ifdef VDEC_ERRCNT_EN
    check("known_err_count", {16'b0, err_count}, 0);
`endif

    // Single channel error on the first bit of pair 2.
    do_reset();
    run_known(1'b1, 0);
`ifdef VDEC_ERRCNT_EN
    check("single_err_count", {16'b0, err_count}, 1);
`endif

    // Gapped input: in_valid alternates 1,0.
    do_reset();
    run_known(1'b0, 1);

    // Reset after an odd number of bits, then replay the known stream.
    do_reset();
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    do_reset();
    run_known(1'b0, 0);

    // Random data, error-free and with sparse errors.
    do_reset();
    run_random(0);
`ifdef VDEC_ERRCNT_EN
    check("random_clean_err_count", {16'b0, err_count}, 0);
`endif
    do_reset();
    run_random(2);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
